// File: rtl/instr_encoder_loader.sv
// Sequential instruction encoder: turns symbolic instructions into 32-bit MIPS
// words and writes them to consecutive IMEM addresses starting at base_addr.
module instr_encoder_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [4:0]        in_mnem,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              load_done,
    output logic              err_illegal,
    output logic              err_overflow,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [1:0] {
        IDLE,
        ACCEPT,
        WRITE,
        DONE
    } state_t;

    state_t state, state_next;
    logic   last_q;
    logic   mnem_legal;

    // Codes 16-31 are the illegal half of the mnemonic space.
    assign mnem_legal = ~in_mnem[4];

    function automatic logic [31:0] encode(
        input logic [4:0]  mnem,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [15:0] imm,
        input logic [25:0] target
    );
        logic [31:0] word;
        word = '0;
        case (mnem)
            5'd0:  word = {6'b000000, rs, rt, rd, 5'b0, 6'b100001}; // addu
            5'd1:  word = {6'b000000, rs, rt, rd, 5'b0, 6'b100011}; // subu
            5'd2:  word = {6'b000000, rs, rt, rd, 5'b0, 6'b100100}; // and
            5'd3:  word = {6'b000000, rs, rt, rd, 5'b0, 6'b100101}; // or
            5'd4:  word = {6'b000000, rs, 15'b0, 6'b001000};        // jr
            5'd5:  word = {6'b001111, 5'b0, rt, imm};               // lui
            5'd6:  word = {6'b100011, rs, rt, imm};                 // lw
            5'd7:  word = {6'b101011, rs, rt, imm};                 // sw
            5'd8:  word = {6'b001101, rs, rt, imm};                 // ori
            5'd9:  word = {6'b000100, rs, rt, imm};                 // beq
            5'd10: word = {6'b000011, target};                      // jal
            5'd11: word = {6'b100001, rs, rt, imm};                 // lh
            5'd12: word = {6'b100000, rs, rt, imm};                 // lb
            5'd13: word = {6'b101000, rs, rt, imm};                 // sb
            5'd14: word = {6'b000010, target};                      // j
            5'd15: word = {6'b001011, rs, rt, imm};                 // sltiu
            default: word = '0;
        endcase
        return word;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every output and next-state signal gets a default first so this
    // block can never infer a latch.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        imem_we    = 1'b0;
        busy       = 1'b0;
        load_done  = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = ACCEPT;
            end
            ACCEPT: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    if (mnem_legal)   state_next = WRITE;
                    else if (in_last) state_next = DONE;
                end
            end
            WRITE: begin
                imem_we = 1'b1;
                busy    = 1'b1;
                if (last_q || (&imem_addr)) state_next = DONE;
                else                        state_next = ACCEPT;
            end
            DONE: begin
                load_done = 1'b1;
                if (start) state_next = ACCEPT;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_addr    <= '0;
            imem_wdata   <= '0;
            word_count   <= '0;
            err_illegal  <= 1'b0;
            err_overflow <= 1'b0;
            last_q       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        imem_addr    <= base_addr;
                        word_count   <= '0;
                        err_illegal  <= 1'b0;
                        err_overflow <= 1'b0;
                    end
                end
                ACCEPT: begin
                    if (in_valid) begin
                        if (mnem_legal) begin
                            imem_wdata <= encode(in_mnem, in_rs, in_rt, in_rd, in_imm, in_target);
                            last_q     <= in_last;
                        end else begin
                            err_illegal <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    word_count <= word_count + (ADDR_W + 1)'(1);
                    // The final word of a session leaves the address parked on it.
                    if (!last_q) begin
                        if (&imem_addr) err_overflow <= 1'b1;
                        else            imem_addr    <= imem_addr + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: directed program loads plus
// randomized sessions compared against a table-driven encoding model.
module tb_instr_encoder_loader;

    localparam int ADDR_W = 10;
    localparam logic [ADDR_W-1:0] TOP_ADDR = '1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_last = 1'b0;
    logic [4:0]        in_mnem = '0;
    logic [4:0]        in_rs = '0;
    logic [4:0]        in_rt = '0;
    logic [4:0]        in_rd = '0;
    logic [15:0]       in_imm = '0;
    logic [25:0]       in_target = '0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              busy;
    logic              load_done;
    logic              err_illegal;
    logic              err_overflow;
    logic [ADDR_W:0]   word_count;

    int checks = 0;
    int failures = 0;

    // Model of the session as seen from outside the block.
    logic [ADDR_W-1:0] m_addr = '0;
    int                m_count = 0;
    bit                m_done = 1'b0;
    bit                m_ill = 1'b0;
    bit                m_ovf = 1'b0;

    // Format class per mnemonic: 0 R-type, 1 jr, 2 lui, 3 I-type, 4 J-type.
    int fmt_tab  [16] = '{0, 0, 0, 0, 1, 2, 3, 3, 3, 3, 4, 3, 3, 3, 4, 3};
    // funct for R-type, opcode otherwise.
    int code_tab [16] = '{33, 35, 36, 37, 8, 15, 35, 43, 13, 4, 3, 33, 32, 40, 2, 11};

    instr_encoder_loader #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .base_addr    (base_addr),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_last      (in_last),
        .in_mnem      (in_mnem),
        .in_rs        (in_rs),
        .in_rt        (in_rt),
        .in_rd        (in_rd),
        .in_imm       (in_imm),
        .in_target    (in_target),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .busy         (busy),
        .load_done    (load_done),
        .err_illegal  (err_illegal),
        .err_overflow (err_overflow),
        .word_count   (word_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_word(input int m, input int rs, input int rt,
                                             input int rd, input int imm, input int tgt);
        longint unsigned w;
        case (fmt_tab[m])
            0:       w = rs * 64'd2097152 + rt * 64'd65536 + rd * 64'd2048 + code_tab[m];
            1:       w = rs * 64'd2097152 + 64'd8;
            2:       w = 64'd15 * 64'd67108864 + rt * 64'd65536 + imm;
            3:       w = code_tab[m] * 64'd67108864 + rs * 64'd2097152 + rt * 64'd65536 + imm;
            default: w = code_tab[m] * 64'd67108864 + tgt;
        endcase
        return w[31:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic check_session(input string tag);
        check({tag, ".word_count"}, 32'(word_count), 32'(m_count));
        check({tag, ".imem_addr"}, 32'(imem_addr), 32'(m_addr));
        check({tag, ".err_illegal"}, 32'(err_illegal), 32'(m_ill));
        check({tag, ".err_overflow"}, 32'(err_overflow), 32'(m_ovf));
        check({tag, ".load_done"}, 32'(load_done), 32'(m_done));
        check({tag, ".busy"}, 32'(busy), 32'(!m_done));
        check({tag, ".imem_we_idle"}, 32'(imem_we), 32'd0);
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] base);
        @(negedge clk);
        start = 1'b1;
        base_addr = base;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        m_addr = base;
        m_count = 0;
        m_done = 1'b0;
        m_ill = 1'b0;
        m_ovf = 1'b0;
        check("start.in_ready", 32'(in_ready), 32'd1);
        check_session("start");
    endtask

    // Offers one instruction at a negedge, waits for its acceptance, then
    // checks the write cycle and the state after it against the model.
    task automatic send(input int m, input int rs, input int rt, input int rd,
                        input int imm, input int tgt, input bit last);
        int guard;
        bit legal;
        logic [31:0] exp_word;
        legal = (m < 16);
        exp_word = legal ? ref_word(m, rs, rt, rd, imm, tgt) : 32'd0;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("send.ready_wait", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_last   = last;
        in_mnem   = 5'(m);
        in_rs     = 5'(rs);
        in_rt     = 5'(rt);
        in_rd     = 5'(rd);
        in_imm    = 16'(imm);
        in_target = 26'(tgt);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (legal) begin
            check("write.imem_we", 32'(imem_we), 32'd1);
            check("write.imem_addr", 32'(imem_addr), 32'(m_addr));
            check("write.imem_wdata", imem_wdata, exp_word);
            check("write.in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
            m_count++;
            if (last) m_done = 1'b1;
            else if (m_addr == TOP_ADDR) begin
                m_ovf = 1'b1;
                m_done = 1'b1;
            end else m_addr = m_addr + 1'b1;
        end else begin
            m_ill = 1'b1;
            if (last) m_done = 1'b1;
        end
        check_session("after");
    endtask

    initial begin
        // Reset state
        #12;
        check("reset.imem_we", 32'(imem_we), 32'd0);
        check("reset.imem_addr", 32'(imem_addr), 32'd0);
        check("reset.imem_wdata", imem_wdata, 32'd0);
        check("reset.word_count", 32'(word_count), 32'd0);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.load_done", 32'(load_done), 32'd0);
        check("reset.in_ready", 32'(in_ready), 32'd0);
        check("reset.errs", 32'({err_illegal, err_overflow}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single addu, last
        do_start(10'h010);
        send(0, 1, 2, 3, 0, 0, 1'b1);
        check("addu.word_const", 32'h00221821, ref_word(0, 1, 2, 3, 0, 0));

        // Four-word program from address 0
        do_start(10'h000);
        send(5, 0, 1, 0, 16'h1234, 0, 1'b0);
        send(8, 1, 1, 0, 16'h5678, 0, 1'b0);
        send(3, 4, 5, 6, 0, 0, 1'b0);
        send(7, 29, 31, 0, 4, 0, 1'b1);
        check("prog.word_count", 32'(word_count), 32'd4);

        // Branch and jumps
        do_start(10'h040);
        send(9, 1, 2, 0, 16'hFFFF, 0, 1'b0);
        send(14, 0, 0, 0, 0, 26'h100, 1'b0);
        send(10, 0, 0, 0, 0, 3, 1'b1);

        // Illegal mnemonic between two legal words
        do_start(10'h020);
        send(0, 7, 8, 9, 0, 0, 1'b0);
        send(20, 1, 1, 1, 0, 0, 1'b0);
        send(1, 3, 4, 5, 0, 0, 1'b1);
        check("illegal.last_addr", 32'(imem_addr), 32'h021);

        // Overflow at the top address; second word never accepted
        do_start(TOP_ADDR);
        send(6, 2, 3, 0, 16'h0010, 0, 1'b0);
        check("ovf.word_count", 32'(word_count), 32'd1);
        in_valid = 1'b1;
        in_mnem  = 5'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ovf.no_accept", 32'(in_ready), 32'd0);
            check("ovf.no_write", 32'(imem_we), 32'd0);
        end
        in_valid = 1'b0;

        // Start pulsed while busy is ignored
        do_start(10'h100);
        @(negedge clk);
        start = 1'b1;
        base_addr = 10'h200;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("busy_start.imem_addr", 32'(imem_addr), 32'h100);
        check("busy_start.busy", 32'(busy), 32'd1);
        send(2, 1, 2, 3, 0, 0, 1'b1);

        // Reset during WRITE
        do_start(10'h080);
        in_valid = 1'b1;
        in_mnem  = 5'd0;
        in_last  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("rst_mid.in_write", 32'(imem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid.imem_we", 32'(imem_we), 32'd0);
        check("rst_mid.busy", 32'(busy), 32'd0);
        check("rst_mid.load_done", 32'(load_done), 32'd0);
        check("rst_mid.word_count", 32'(word_count), 32'd0);
        @(negedge clk);
        check("rst_mid.still_idle_we", 32'(imem_we), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Randomized sessions; the last one sits near the top address
        for (int s = 0; s < 6; s++) begin
            int len;
            do_start((s == 5) ? 10'h3FC : 10'($urandom_range(0, 1000)));
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) begin
                int m;
                m = ($urandom_range(0, 9) == 0) ? $urandom_range(16, 31) : $urandom_range(0, 15);
                send(m, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 65535), $urandom_range(0, 32'h3FFFFFF), i == len - 1);
                if (m_done) break;
            end
            check("rand.done", 32'(load_done), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Sequential instruction encoder: the inverse of the main control decoder. It accepts symbolic instructions (mnemonic code plus fields) over a valid/ready handshake, encodes each into a 32-bit MIPS word, and writes the words to consecutive instruction-memory addresses.
- Used at boot or by the test harness to load programs into IMEM before the pipeline is released from stall.
- Encodes exactly the opcode/funct set the CPU decodes.

Parameters:
- ADDR_W, 10, IMEM word-address width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a load session at base_addr; one-cycle pulse
- base_addr  in  ADDR_W  first IMEM word address of the session
- in_valid  in  1  instruction fields are valid
- in_ready  out  1  encoder can accept fields this cycle
- in_last  in  1  qualifies the final instruction of the session
- in_mnem  in  5  mnemonic code, see Behaviour
- in_rs  in  5  rs field
- in_rt  in  5  rt field
- in_rd  in  5  rd field
- in_imm  in  16  immediate
- in_target  in  26  jump target
- imem_we  out  1  IMEM write strobe
- imem_addr  out  ADDR_W  IMEM word address
- imem_wdata  out  32  encoded instruction
- busy  out  1  session in progress
- load_done  out  1  level; session finished; cleared by the next start
- err_illegal  out  1  sticky; an illegal mnemonic was received this session
- err_overflow  out  1  sticky; the top address was written before in_last
- word_count  out  ADDR_W+1  words written this session

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs are 0, including imem_addr, imem_wdata and word_count.
- Mnemonic codes (field layouts):
  - R-type {000000,rs,rt,rd,00000,funct}: 0 addu (funct 100001), 1 subu (100011), 2 and (100100), 3 or (100101).
  - jr: 4, {000000,rs,15'b0,001000}.
  - lui: 5, {001111,00000,rt,imm}; rs is forced to 0.
  - I-type {op,rs,rt,imm}: 6 lw (100011), 7 sw (101011), 8 ori (001101), 9 beq (000100), 11 lh (100001), 12 lb (100000), 13 sb (101000), 15 sltiu (001011).
  - J-type {op,target}: 10 jal (000011), 14 j (000010).
  - Codes 16-31 are illegal.
- FSM states: IDLE, ACCEPT, WRITE, DONE.
- IDLE:
  - in_ready=0.
  - On start: imem_addr<=base_addr, word_count<=0, both error flags cleared, load_done<=0; go to ACCEPT.
- ACCEPT:
  - in_ready=1; busy=1.
  - On in_valid, legal code: imem_wdata<=encoded word, latch in_last; go to WRITE.
  - On in_valid, illegal code: set err_illegal, write nothing. If in_last, go to DONE; else stay in ACCEPT.
- WRITE:
  - in_ready=0; imem_we=1 for exactly this one cycle at the current imem_addr.
  - Next edge: word_count+=1.
  - If the latched last is set: go to DONE; imem_addr does not increment.
  - Else if imem_addr equals all-ones: set err_overflow, go to DONE, imem_addr holds.
  - Else: imem_addr+=1, go to ACCEPT.
- DONE:
  - load_done=1, busy=0, in_ready=0.
  - On start: same actions as start in IDLE.
- Timing:
  - Latency: handshake accepted at edge N → imem_we high in cycle N+1.
  - Maximum throughput is one word per 2 cycles.
- start is ignored while busy=1.
- imem_wdata and imem_addr hold their last values outside WRITE.
- Reset asserted mid-session aborts the session immediately; no partial write strobe follows.

Test Plan:
- Start with base_addr=0x010, then addu rs=1 rt=2 rd=3 with in_last=1 → imem_we exactly one cycle after acceptance, addr 0x010, data 0x00221821; word_count=1; load_done=1.
- Stream lui rt=1 imm=0x1234, ori rs=1 rt=1 imm=0x5678, or rs=4 rt=5 rd=6, sw rs=29 rt=31 imm=4 (last), base_addr=0 → data 0x3C011234, 0x34215678, 0x00853025, 0xAFBF0004 at addrs 0-3; word_count=4.
- Stream beq rs=1 rt=2 imm=0xFFFF, j target=0x100, jal target=3 → 0x1022FFFF, 0x08000100, 0x0C000003.
- Mnemonic 20 between two legal words → err_illegal=1; no write for it; the following word lands at the next consecutive address.
- base_addr=0x3FF with two instructions, the second not yet sent → after the first write err_overflow=1, load_done=1, word_count=1; the second is never accepted.
- rst_n low during WRITE → imem_we, busy and load_done drop to 0 immediately. Start pulsed while busy → ignored, with imem_addr unchanged.
